// File: rtl/percentile_multithresh_if.sv
// Pixel-side bundle for percentile_multithresh.
// Purpose: groups the gray stream inputs and the quantiser/threshold outputs
// so the block connects with a single port. Clock and reset stay outside.
//   iFval       frame valid (falling edge ends the frame)
//   iGray       gray pixel, iGrayValid qualifies it
//   iX_Cont     pixel column, iY_Cont pixel row
//   oPixel      quantised pixel, oLevel quantisation level, oValid qualifier
//   oThresh     packed thresholds, threshold k-1 at [k*GRAY_W-1 -: GRAY_W]
//   oTotal      pixels counted in the last completed frame
//   oDone       pulse when new thresholds are committed
//   oSkip       pulse when a frame is not accumulated
// Modports: master drives the stream (source side), slave is the block.
interface percentile_multithresh_if #(
   parameter int GRAY_W     = 8,
   parameter int CNT_W      = 20,
   parameter int NUM_THRESH = 3
);
   logic                         iFval;
   logic [GRAY_W-1:0]            iGray;
   logic                         iGrayValid;
   logic [15:0]                  iX_Cont;
   logic [15:0]                  iY_Cont;
   logic [GRAY_W-1:0]            oPixel;
   logic [3:0]                   oLevel;
   logic                         oValid;
   logic [NUM_THRESH*GRAY_W-1:0] oThresh;
   logic [CNT_W-1:0]             oTotal;
   logic                         oDone;
   logic                         oSkip;

   modport master (
      output iFval, iGray, iGrayValid, iX_Cont, iY_Cont,
      input  oPixel, oLevel, oValid, oThresh, oTotal, oDone, oSkip
   );

   modport slave (
      input  iFval, iGray, iGrayValid, iX_Cont, iY_Cont,
      output oPixel, oLevel, oValid, oThresh, oTotal, oDone, oSkip
   );
endinterface

// File: rtl/percentile_multithresh.sv
// Percentile multi-threshold quantiser.
// Purpose: builds a per-frame gray histogram, and at frame end scans the
// cumulative sum to find NUM_THRESH equally spaced percentile thresholds.
// The live gray stream is quantised into NUM_THRESH+1 levels using the
// thresholds committed at the previous scan.
// Ports:
//   iClk        pixel clock
//   iRst_n      asynchronous active-low reset
//   bus         percentile_multithresh_if.slave (stream in, quantiser and
//               threshold results out)
// Optional build macro: THRESH_ROI_EN restricts histogram/total counting to
// the inclusive window ROI_X0..ROI_X1 x ROI_Y0..ROI_Y1. Without it every
// valid pixel counts and the X/Y inputs are ignored.
//
// state | meaning
// ACCUM | accumulate histogram while the frame is valid; idle between frames
// CLEAR | zero every bin once after reset (RAM content undefined)
// DRAIN | one extra cycle so the last read-modify-write lands before the scan
// SCAN  | read+zero each bin, build the cumulative sum, capture thresholds
module percentile_multithresh #(
   parameter int GRAY_W     = 8,
   parameter int CNT_W      = 20,
   parameter int NUM_THRESH = 3,
   parameter int ROI_X0     = 0,
   parameter int ROI_X1     = 639,
   parameter int ROI_Y0     = 0,
   parameter int ROI_Y1     = 479
) (
   input  logic                     iClk,
   input  logic                     iRst_n,
   percentile_multithresh_if.slave  bus
);
   localparam int NBINS = 2**GRAY_W;
   localparam int CMP_W = CNT_W + 5;
   localparam int STEP  = (NBINS - 1) / NUM_THRESH;
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [GRAY_W:0]   LAST_IDX = (GRAY_W+1)'(NBINS - 1);
   localparam logic [GRAY_W:0]   SCAN_END = (GRAY_W+1)'(NBINS);

   typedef enum logic [1:0] {ACCUM, CLEAR, DRAIN, SCAN} state_t;

   state_t                       state_q, state_d;
   logic                         fval_q;
   logic                         need_clr_q, need_clr_d;
   logic                         acc_en_q, acc_en_d;
   logic [GRAY_W:0]              idx_q, idx_d;

   logic [CNT_W-1:0]             hist_q [NBINS];
   logic [CNT_W-1:0]             rd_data_q;
   logic [GRAY_W-1:0]            rd_addr, wr_addr;
   logic                         wr_en;
   logic [CNT_W-1:0]             wr_data;

   logic                         s1_vld_q;
   logic [GRAY_W-1:0]            s1_addr_q;
   logic                         w_vld_q;
   logic [GRAY_W-1:0]            w_addr_q;
   logic [CNT_W-1:0]             w_data_q;

   logic [CNT_W-1:0]             total_q, total_d;
   logic [CNT_W-1:0]             cum_q, cum_d;
   logic [CNT_W:0]               cum_sum;
   logic [GRAY_W:0]              prev_idx;
   logic [NUM_THRESH-1:0]        cap_q, cap_d;
   logic [GRAY_W-1:0]            th_scan_q [NUM_THRESH];
   logic [GRAY_W-1:0]            th_scan_d [NUM_THRESH];
   logic [NUM_THRESH*GRAY_W-1:0] thresh_q, thresh_d;
   logic [CNT_W-1:0]             tot_out_q, tot_out_d;
   logic                         done_q, done_d, skip_q, skip_d;

   logic                         rise, fall, frame_ok, hit, in_roi;
   logic [CNT_W-1:0]             rmw_base, rmw_inc;

   logic [GRAY_W-1:0]            g1_q;
   logic                         v1_q;
   logic [3:0]                   lvl;
   logic [GRAY_W-1:0]            px;
   logic [3:0]                   lvl_q;
   logic [GRAY_W-1:0]            pix_q;
   logic                         val_q;

`ifdef THRESH_ROI_EN
   assign in_roi = (int'(bus.iX_Cont) >= ROI_X0) && (int'(bus.iX_Cont) <= ROI_X1) &&
                   (int'(bus.iY_Cont) >= ROI_Y0) && (int'(bus.iY_Cont) <= ROI_Y1);
`else
   logic unused_roi;
   assign in_roi     = 1'b1;
   assign unused_roi = ^{bus.iX_Cont, bus.iY_Cont, 32'(ROI_X0), 32'(ROI_X1),
                         32'(ROI_Y0), 32'(ROI_Y1)};
`endif

   // Single-port-style histogram RAM, registered read. A write and a read of
   // the same address in one cycle return the old value, which SCAN relies on
   // to read a bin and zero it together.
   always_ff @(posedge iClk) begin
      rd_data_q <= hist_q[rd_addr];
      if (wr_en) hist_q[wr_addr] <= wr_data;
   end

   always_comb begin
      rise     = bus.iFval & ~fval_q;
      fall     = ~bus.iFval & fval_q;
      // A frame is accumulated only if it starts while ACCUM is idle and clean.
      frame_ok = rise ? (state_q == ACCUM && !need_clr_q) : acc_en_q;
      hit      = (state_q == ACCUM) & frame_ok & bus.iFval & bus.iGrayValid & in_roi;

      // The read issued one cycle after a write to the same bin saw the old
      // value; the write stage holds the fresh one.
      rmw_base = (w_vld_q && w_addr_q == s1_addr_q) ? w_data_q : rd_data_q;
      rmw_inc  = (rmw_base == CNT_MAX) ? rmw_base : rmw_base + CNT_W'(1);

      state_d    = state_q;
      need_clr_d = need_clr_q;
      acc_en_d   = frame_ok;
      idx_d      = idx_q;
      total_d    = total_q;
      cum_d      = cum_q;
      cum_sum    = '0;
      prev_idx   = idx_q - (GRAY_W+1)'(1);
      cap_d      = cap_q;
      th_scan_d  = th_scan_q;
      thresh_d   = thresh_q;
      tot_out_d  = tot_out_q;
      done_d     = 1'b0;
      skip_d     = rise & ~(state_q == ACCUM && !need_clr_q);
      rd_addr    = bus.iGray;
      wr_en      = s1_vld_q;
      wr_addr    = s1_addr_q;
      wr_data    = rmw_inc;

      if (hit && total_q != CNT_MAX) total_d = total_q + CNT_W'(1);

      unique case (state_q)
         ACCUM: begin
            if (need_clr_q && !bus.iFval) begin
               state_d = CLEAR;
               idx_d   = '0;
            end else if (fall && acc_en_q) begin
               state_d = DRAIN;
            end
         end
         CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = idx_q[GRAY_W-1:0];
            wr_data = '0;
            idx_d   = idx_q + (GRAY_W+1)'(1);
            if (idx_q == LAST_IDX) begin
               state_d    = ACCUM;
               need_clr_d = 1'b0;
            end
         end
         DRAIN: begin
            state_d = SCAN;
            idx_d   = '0;
            cum_d   = '0;
            cap_d   = '0;
         end
         SCAN: begin
            if (!idx_q[GRAY_W]) begin
               rd_addr = idx_q[GRAY_W-1:0];
               wr_en   = 1'b1;
               wr_addr = idx_q[GRAY_W-1:0];
               wr_data = '0;
            end
            // rd_data_q holds bin idx_q-1 here.
            if (idx_q != '0) begin
               cum_sum = {1'b0, cum_q} + {1'b0, rd_data_q};
               cum_d   = cum_sum[CNT_W] ? CNT_MAX : cum_sum[CNT_W-1:0];
               for (int k = 0; k < NUM_THRESH; k++) begin
                  if (!cap_q[k] && (CMP_W'(cum_d) * CMP_W'(NUM_THRESH + 1) >=
                                    CMP_W'(total_q) * CMP_W'(k + 1))) begin
                     cap_d[k]     = 1'b1;
                     th_scan_d[k] = prev_idx[GRAY_W-1:0];
                  end
               end
            end
            idx_d = idx_q + (GRAY_W+1)'(1);
            if (idx_q == SCAN_END) begin
               for (int k = 0; k < NUM_THRESH; k++)
                  thresh_d[k*GRAY_W +: GRAY_W] = cap_d[k] ? th_scan_d[k] : '1;
               tot_out_d = total_q;
               total_d   = '0;
               done_d    = 1'b1;
               state_d   = ACCUM;
            end
         end
      endcase
   end

   always_comb begin
      lvl = '0;
      for (int k = 0; k < NUM_THRESH; k++)
         if (g1_q > thresh_q[k*GRAY_W +: GRAY_W]) lvl = lvl + 4'd1;
      px = (lvl == 4'(NUM_THRESH)) ? '1 : GRAY_W'(32'(lvl) * STEP);
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q    <= ACCUM;
         fval_q     <= 1'b0;
         need_clr_q <= 1'b1;
         acc_en_q   <= 1'b0;
         idx_q      <= '0;
         s1_vld_q   <= 1'b0;
         s1_addr_q  <= '0;
         w_vld_q    <= 1'b0;
         w_addr_q   <= '0;
         w_data_q   <= '0;
         total_q    <= '0;
         cum_q      <= '0;
         cap_q      <= '0;
         for (int k = 0; k < NUM_THRESH; k++) begin
            th_scan_q[k]                 <= '0;
            thresh_q[k*GRAY_W +: GRAY_W] <= GRAY_W'(((k + 1) * NBINS) / (NUM_THRESH + 1));
         end
         tot_out_q  <= '0;
         done_q     <= 1'b0;
         skip_q     <= 1'b0;
         g1_q       <= '0;
         v1_q       <= 1'b0;
         lvl_q      <= '0;
         pix_q      <= '0;
         val_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fval_q     <= bus.iFval;
         need_clr_q <= need_clr_d;
         acc_en_q   <= acc_en_d;
         idx_q      <= idx_d;
         s1_vld_q   <= hit;
         s1_addr_q  <= bus.iGray;
         w_vld_q    <= s1_vld_q;
         w_addr_q   <= s1_addr_q;
         w_data_q   <= rmw_inc;
         total_q    <= total_d;
         cum_q      <= cum_d;
         cap_q      <= cap_d;
         th_scan_q  <= th_scan_d;
         thresh_q   <= thresh_d;
         tot_out_q  <= tot_out_d;
         done_q     <= done_d;
         skip_q     <= skip_d;
         g1_q       <= bus.iGray;
         v1_q       <= bus.iGrayValid;
         lvl_q      <= lvl;
         pix_q      <= px;
         val_q      <= v1_q;
      end
   end

   assign bus.oPixel  = pix_q;
   assign bus.oLevel  = lvl_q;
   assign bus.oValid  = val_q;
   assign bus.oThresh = thresh_q;
   assign bus.oTotal  = tot_out_q;
   assign bus.oDone   = done_q;
   assign bus.oSkip   = skip_q;
endmodule

// File: tb/tb_percentile_multithresh.sv
module tb_percentile_multithresh;
   localparam int GRAY_W     = 8;
   localparam int CNT_W      = 20;
   localparam int NUM_THRESH = 3;
`ifdef THRESH_ROI_EN
   localparam int RX0 = 0, RX1 = 9, RY0 = 0, RY1 = 0;
`else
   localparam int RX0 = 0, RX1 = 639, RY0 = 0, RY1 = 479;
`endif
   // fall of iFval to oDone: 2 drain cycles + 257 scan cycles
   localparam int DONE_LAT = 259;

   typedef struct {
      logic [3:0] lvl;
      logic [7:0] pix;
   } pexp_t;

   typedef struct {
      logic [NUM_THRESH*GRAY_W-1:0] th;
      int                           tot;
      int                           c0;
   } dexp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   percentile_multithresh_if #(.GRAY_W(GRAY_W), .CNT_W(CNT_W), .NUM_THRESH(NUM_THRESH)) bus ();

   percentile_multithresh #(
      .GRAY_W(GRAY_W), .CNT_W(CNT_W), .NUM_THRESH(NUM_THRESH),
      .ROI_X0(RX0), .ROI_X1(RX1), .ROI_Y0(RY0), .ROI_Y1(RY1)
   ) dut (
      .iClk(clk),
      .iRst_n(rst_n),
      .bus(bus)
   );

   int    errors = 0;
   int    checks = 0;
   pexp_t pq[$];
   dexp_t dq[$];
   int    skip_exp = 0;
   int    skip_seen = 0;

   int         hist [256];
   int         total = 0;
   bit         frame_acc = 0;
   int         px_idx = 0;
   logic [7:0] cur_th [NUM_THRESH];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic bit in_roi(input int x, input int y);
`ifdef THRESH_ROI_EN
      return (x >= RX0) && (x <= RX1) && (y >= RY0) && (y <= RY1);
`else
      return (x >= 0) && (y >= 0);
`endif
   endfunction

   function automatic pexp_t quant(input logic [7:0] g);
      pexp_t r;
      int    n = 0;
      for (int k = 0; k < NUM_THRESH; k++)
         if (g > cur_th[k]) n++;
      r.lvl = 4'(n);
      r.pix = (n == NUM_THRESH) ? 8'd255 : 8'(n * (255 / NUM_THRESH));
      return r;
   endfunction

   // Threshold k: first bin where the running count reaches k/(N+1) of total.
   task automatic ref_thresh(output logic [NUM_THRESH*GRAY_W-1:0] th);
      for (int k = 1; k <= NUM_THRESH; k++) begin
         int cum = 0;
         int t = 255;
         bit found = 0;
         for (int b = 0; b < 256; b++) begin
            cum += hist[b];
            if (!found && cum * (NUM_THRESH + 1) >= total * k) begin
               t = b;
               found = 1;
            end
         end
         th[(k-1)*8 +: 8] = 8'(t);
      end
   endtask

   task automatic start_frame(input bit acc, input bit skip);
      bus.iFval = 1'b1;
      frame_acc = acc;
      px_idx = 0;
      if (skip) skip_exp++;
      tick();
   endtask

   task automatic send_px(input logic [7:0] g, input bit v);
      int x = px_idx % 640;
      int y = px_idx / 640;
      bus.iGray = g;
      bus.iGrayValid = v;
      bus.iX_Cont = 16'(x);
      bus.iY_Cont = 16'(y);
      if (v) begin
         pq.push_back(quant(g));
         if (frame_acc && bus.iFval && in_roi(x, y)) begin
            hist[g]++;
            total++;
         end
         px_idx++;
      end
      tick();
      bus.iGrayValid = 1'b0;
   endtask

   task automatic end_frame(input int gap);
      dexp_t d;
      bus.iFval = 1'b0;
      if (frame_acc) begin
         ref_thresh(d.th);
         d.tot = total;
         d.c0 = cyc;
         dq.push_back(d);
         for (int k = 0; k < NUM_THRESH; k++) cur_th[k] = d.th[k*8 +: 8];
         for (int b = 0; b < 256; b++) hist[b] = 0;
         total = 0;
      end
      frame_acc = 0;
      repeat (gap) tick();
   endtask

   task automatic random_frame(input int n);
      start_frame(1, 0);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) send_px(8'($urandom_range(0, 255)), 1'b0);
         send_px(8'($urandom_range(0, 255)), 1'b1);
      end
      end_frame(300);
   endtask

   // monitor / scoreboard
   initial begin
      pexp_t e;
      dexp_t d;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.oValid) begin
               checks++;
               if (pq.size() == 0) begin
                  errors++;
                  $display("FAIL pix_unexpected: oValid with level=%0d pixel=%0d, none expected",
                           bus.oLevel, bus.oPixel);
               end else begin
                  e = pq.pop_front();
                  if (bus.oLevel !== e.lvl || bus.oPixel !== e.pix) begin
                     errors++;
                     $display("FAIL pix: got level=%0d pixel=%0d expected level=%0d pixel=%0d",
                              bus.oLevel, bus.oPixel, e.lvl, e.pix);
                  end
               end
            end
            if (bus.oDone) begin
               checks++;
               if (dq.size() == 0) begin
                  errors++;
                  $display("FAIL done_unexpected: oDone with thresh=%h, none expected", bus.oThresh);
               end else begin
                  checks--;
                  d = dq.pop_front();
                  chk("done_thresh", longint'(bus.oThresh), longint'(d.th));
                  chk("done_total", longint'(bus.oTotal), longint'(d.tot));
                  chk("done_latency", longint'(cyc - d.c0), longint'(DONE_LAT));
               end
            end
            if (bus.oSkip) skip_seen++;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: run exceeded %0d time units", 1000000);
      $fatal(1, "watchdog");
   end

   initial begin
      int arr [400];
      for (int b = 0; b < 256; b++) hist[b] = 0;
      for (int k = 0; k < NUM_THRESH; k++) cur_th[k] = 8'(((k + 1) * 256) / (NUM_THRESH + 1));
      bus.iFval = 1'b0;
      bus.iGray = '0;
      bus.iGrayValid = 1'b0;
      bus.iX_Cont = '0;
      bus.iY_Cont = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      chk("reset_thresh", longint'(bus.oThresh), longint'({8'd192, 8'd128, 8'd64}));
      chk("reset_valid", longint'(bus.oValid), 0);
      chk("reset_level", longint'(bus.oLevel), 0);
      chk("reset_pixel", longint'(bus.oPixel), 0);
      chk("reset_total", longint'(bus.oTotal), 0);
      chk("reset_done", longint'(bus.oDone), 0);
      chk("reset_skip", longint'(bus.oSkip), 0);

      // first frame lands during the post-reset clear: skipped, still quantised
      repeat (10) tick();
      start_frame(0, 1);
      for (int i = 0; i < 20; i++) send_px(8'($urandom_range(0, 255)), 1'b1);
      end_frame(300);

      // 100 each of 10/50/90/200 in random order
      for (int i = 0; i < 400; i++) arr[i] = (i < 100) ? 10 : (i < 200) ? 50 : (i < 300) ? 90 : 200;
      for (int i = 399; i > 0; i--) begin
         int j = $urandom_range(0, i);
         int t = arr[i];
         arr[i] = arr[j];
         arr[j] = t;
      end
      start_frame(1, 0);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 4) == 0) send_px(8'($urandom_range(0, 255)), 1'b0);
         send_px(8'(arr[i]), 1'b1);
      end
      end_frame(300);

      // same bin every cycle: forwarding path
      start_frame(1, 0);
      for (int i = 0; i < 1000; i++) send_px(8'd7, 1'b1);
      end_frame(300);

      start_frame(1, 0);
      send_px(8'd7, 1'b1);
      send_px(8'd8, 1'b1);
      for (int i = 0; i < 60; i++) send_px(8'($urandom_range(0, 255)), 1'b1);
      end_frame(300);

      // empty frame
      start_frame(1, 0);
      repeat (20) tick();
      end_frame(300);
      random_frame(80);

      // next frame rises 10 cycles into the scan: skipped
      start_frame(1, 0);
      for (int i = 0; i < 150; i++) send_px(8'($urandom_range(0, 255)), 1'b1);
      end_frame(12);
      start_frame(0, 1);
      repeat (270) tick();
      for (int i = 0; i < 50; i++) send_px(8'($urandom_range(0, 255)), 1'b1);
      end_frame(20);
      random_frame(200);

      repeat (3) random_frame($urandom_range(50, 300));

      // 640x2 frame, gray 20 in the top-left 10 pixels, bright elsewhere
      start_frame(1, 0);
      for (int i = 0; i < 1280; i++) send_px((i < 10) ? 8'd20 : 8'd240, 1'b1);
      end_frame(300);

      chk("pix_queue_drained", longint'(pq.size()), 0);
      chk("done_queue_drained", longint'(dq.size()), 0);
      chk("skip_count", longint'(skip_seen), longint'(skip_exp));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
